// File: rtl/mac_fp32_accum_seq_if.sv
// Handshake/bus bundle for mac_fp32_accum_seq.
//  start/len      : run request (len = number of FP32 terms)
//  in_*           : term stream, valid/ready
//  add_g_*/add_l_*: greater/lesser-magnitude operands to the external adder
//  add_o_*        : registered result from the external adder
//  out_*          : final sum, valid/ready
//  busy           : sequencer not idle
// master = producer/consumer/adder side, slave = sequencer.
interface mac_fp32_accum_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             add_g_sign;
  logic [7:0]       add_g_exp;
  logic [22:0]      add_g_mant;
  logic             add_l_sign;
  logic [7:0]       add_l_exp;
  logic [22:0]      add_l_mant;
  logic             add_o_sign;
  logic [7:0]       add_o_exp;
  logic [22:0]      add_o_mant;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, add_o_sign, add_o_exp, add_o_mant, out_ready,
    input  in_ready, add_g_sign, add_g_exp, add_g_mant, add_l_sign, add_l_exp, add_l_mant,
           out_valid, out_data, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, add_o_sign, add_o_exp, add_o_mant, out_ready,
    output in_ready, add_g_sign, add_g_exp, add_g_mant, add_l_sign, add_l_exp, add_l_mant,
           out_valid, out_data, busy
  );
endinterface

// File: rtl/mac_fp32_accum_seq.sv
// FP32 accumulation sequencer for the MAC unit's single-cycle adder.
// Takes len terms over a valid/ready stream, keeps a running FP32 sum and
// feeds each add to the external adder as (greater, lesser) by magnitude.
// Ports:
//  clk  : clock, rising edge
//  rst  : asynchronous active-high reset, aborts any run
//  bus  : mac_fp32_accum_seq_if.slave (start/len, in_*, add_*, out_*, busy)
module mac_fp32_accum_seq #(
  parameter int LEN_W      = 8,
  parameter bit ZERO_CANON = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  mac_fp32_accum_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      g_q, g_d;
  logic [31:0]      l_q, l_d;
  logic [31:0]      sum_w;
  logic             o_zero;

  // Adder result with an optional +0 canonicalisation of zero magnitudes.
  assign o_zero = (bus.add_o_exp == 8'd0) && (bus.add_o_mant == 23'd0);
  assign sum_w  = {bus.add_o_sign & ~(ZERO_CANON && o_zero), bus.add_o_exp, bus.add_o_mant};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      acc_q   <= '0;
      g_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      g_q     <= g_d;
      l_q     <= l_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    acc_d   = acc_q;
    g_d     = g_q;
    l_d     = l_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            acc_d   = '0;
            state_d = S_RESULT;
          end else begin
            cnt_d   = bus.len;
            first_d = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (bus.in_valid) begin
          if (first_q) begin
            // First term seeds the accumulator without an add.
            acc_d   = bus.in_data;
            cnt_d   = cnt_q - 1'b1;
            first_d = 1'b0;
            state_d = (cnt_q == LEN_W'(1)) ? S_RESULT : S_FETCH;
          end else begin
            // Magnitude order on {exp,mant}; a tie keeps acc on the greater port.
            if (acc_q[30:0] >= bus.in_data[30:0]) begin
              g_d = acc_q;
              l_d = bus.in_data;
            end else begin
              g_d = bus.in_data;
              l_d = acc_q;
            end
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        acc_d   = sum_w;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == LEN_W'(1)) ? S_RESULT : S_FETCH;
      end
      S_RESULT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_FETCH);
  assign bus.out_valid  = (state_q == S_RESULT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_data   = acc_q;
  assign bus.add_g_sign = g_q[31];
  assign bus.add_g_exp  = g_q[30:23];
  assign bus.add_g_mant = g_q[22:0];
  assign bus.add_l_sign = l_q[31];
  assign bus.add_l_exp  = l_q[30:23];
  assign bus.add_l_mant = l_q[22:0];

endmodule

// File: tb/tb_mac_fp32_accum_seq.sv
// Self-checking bench for mac_fp32_accum_seq. The external adder and the
// expected sums/orderings are modelled with real arithmetic on exactly
// representable values (multiples of 0.25).
module tb_mac_fp32_accum_seq;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] tq[$];
  logic [31:0] last_out;

  mac_fp32_accum_seq_if #(.LEN_W(LEN_W)) bus ();

  mac_fp32_accum_seq #(.LEN_W(LEN_W), .ZERO_CANON(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic real fp2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2fp(input real x);
    real a;
    int  e;
    logic s;
    logic [7:0]  eb;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = 23'($rtoi((a - 1.0) * 8388608.0));
    eb = 8'(e);
    return {s, eb, m};
  endfunction

  // External adder: registered, and yields a signed zero following the
  // greater operand so zero canonicalisation in the sequencer is exercised.
  function automatic logic [31:0] fadd(input logic [31:0] g, input logic [31:0] l);
    real s;
    s = fp2r(g) + fp2r(l);
    if (s == 0.0) return {g[31], 31'h0};
    return r2fp(s);
  endfunction

  always @(posedge clk)
    {bus.add_o_sign, bus.add_o_exp, bus.add_o_mant} <= fadd(
      {bus.add_g_sign, bus.add_g_exp, bus.add_g_mant},
      {bus.add_l_sign, bus.add_l_exp, bus.add_l_mant});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gword();
    return {bus.add_g_sign, bus.add_g_exp, bus.add_g_mant};
  endfunction
  function automatic logic [31:0] lword();
    return {bus.add_l_sign, bus.add_l_exp, bus.add_l_mant};
  endfunction

  function automatic logic [31:0] rnd_term();
    int k;
    k = int'($urandom_range(0, 128)) - 64;
    return r2fp(real'(k) * 0.25);
  endfunction

  // Runs one accumulation of the terms in tq and checks it cycle by cycle.
  task automatic run(input int gapmax, input int hold, input bit pulse, input int abort_at);
    int n, gap;
    real acc_r, x;
    logic [31:0] eg, el, gsav, lsav, exp_sum;
    n = tq.size();
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    acc_r = 0.0;
    for (int i = 0; i < n; i++) begin
      x = fp2r(tq[i]);
      chk("fetch_in_ready", 32'(bus.in_ready), 32'd1);
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
          chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = tq[i];
      @(posedge clk); #1;
      if (i == 0) begin
        acc_r = x;
      end else begin
        eg = ((acc_r < 0.0 ? -acc_r : acc_r) >= (x < 0.0 ? -x : x)) ? r2fp(acc_r) : tq[i];
        el = (eg === tq[i] && r2fp(acc_r) !== tq[i]) ? r2fp(acc_r) : tq[i];
        if ((acc_r < 0.0 ? -acc_r : acc_r) >= (x < 0.0 ? -x : x)) el = tq[i];
        else el = r2fp(acc_r);
        chk("issue_g", gword(), eg);
        chk("issue_l", lword(), el);
        chk("issue_in_ready", 32'(bus.in_ready), 32'd0);
        if (pulse && i == 1) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'(3);
        end
        gsav = gword();
        lsav = lword();
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("wait_in_ready", 32'(bus.in_ready), 32'd0);
        chk("wait_g_hold", gword(), gsav);
        chk("wait_l_hold", lword(), lsav);
        if (abort_at == i) begin
          rst = 1'b1;
          @(posedge clk); #1;
          chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
          chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
          chk("abort_busy", 32'(bus.busy), 32'd0);
          chk("abort_out_data", bus.out_data, 32'd0);
          chk("abort_g", gword(), 32'd0);
          chk("abort_l", lword(), 32'd0);
          rst = 1'b0;
          bus.in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        acc_r = acc_r + x;
      end
    end
    bus.in_valid = 1'b0;
    exp_sum = r2fp(acc_r);
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("out_data", bus.out_data, exp_sum);
    last_out = bus.out_data;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, exp_sum);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("done_valid", 32'(bus.out_valid), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] gs, ls, t;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_g", gword(), 32'd0);
    chk("rst_l", lword(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.0 + 2.0 with in_valid held high
    tq = '{32'h3F800000, 32'h40000000};
    run(0, 0, 1'b0, -1);
    chk("t1_sum", last_out, 32'h40400000);

    // 1.0 + -1.0 tie, and -1.0 + 1.0 giving a canonical +0
    tq = '{32'h3F800000, 32'hBF800000};
    run(0, 1, 1'b0, -1);
    chk("t2_zero", last_out, 32'h0);
    tq = '{32'hBF800000, 32'h3F800000};
    run(1, 0, 1'b0, -1);
    chk("t2_negzero", last_out, 32'h0);

    // len=0 and len=1
    tq = {};
    run(0, 0, 1'b0, -1);
    chk("t3_len0", last_out, 32'h0);
    gs = gword(); ls = lword();
    tq = '{32'hC0A00000};
    run(0, 2, 1'b0, -1);
    chk("t3_len1", last_out, 32'hC0A00000);
    chk("t3_g_untouched", gword(), gs);
    chk("t3_l_untouched", lword(), ls);

    // 1 + 4 + 0.5 - 2 with input gaps and output back-pressure
    tq = '{32'h3F800000, 32'h40800000, 32'h3F000000, 32'hC0000000};
    run(3, 5, 1'b0, -1);
    chk("t4_sum", last_out, 32'h40600000);

    // reset during WAIT of term 3 of 4, then a len=1 run
    tq = {};
    repeat (4) tq.push_back(rnd_term());
    run(0, 0, 1'b0, 2);
    t = r2fp(7.25);
    tq = '{t};
    run(0, 0, 1'b0, -1);
    chk("t5_after_rst", last_out, t);

    // start pulsed while busy
    tq = {};
    repeat (6) tq.push_back(rnd_term());
    run(1, 1, 1'b1, -1);

    // random runs
    for (int r = 0; r < 10; r++) begin
      tq = {};
      repeat ($urandom_range(1, 12)) tq.push_back(rnd_term());
      run(2, int'($urandom_range(0, 3)), 1'b0, -1);
    end

    // maximum length
    tq = {};
    repeat (255) tq.push_back(rnd_term());
    run(0, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
